mult_seq_ctrl: RTL and testbench

- Upstream sequencer for the shift-add multiplier (`mult`).
- Accepts an operand pair over a valid/ready handshake and drives the multiplier's `multicand`/`multiplier`/`ld1`/`ld2`/`STRT`/`shft_con` on a fixed schedule.
- Counts the shift cycles, captures product `P`, and presents it downstream over a valid/ready handshake with backpressure.
- Replaces hand-driven load/start sequencing with a deterministic FSM.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: FSM state
// encoding and default operand width / multiplier latency.
package mult_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int MULT_LAT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    RUN,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: accepts an operand pair, walks the
// core through load/start/shift, captures P and hands it downstream.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     multicand,
  output logic [WIDTH-1:0]     multiplier,
  output logic                 ld1,
  output logic                 ld2,
  output logic                 STRT,
  output logic                 shft_con,
  input  logic [2*WIDTH-1:0]   P,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy
);

  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // Operands only change on an IDLE handshake, so they are stable for the
  // whole load/start/run/capture window without extra gating.
  assign multicand  = op_a;
  assign multiplier = op_b;
  assign busy       = (state != IDLE);

  // Every control output is registered alongside the state it belongs to,
  // so each strobe is high exactly during its state's cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      in_ready  <= 1'b0;
      ld1       <= 1'b0;
      ld2       <= 1'b0;
      STRT      <= 1'b0;
      shft_con  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      ld1      <= 1'b0;
      ld2      <= 1'b0;
      STRT     <= 1'b0;
      shft_con <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            in_ready <= 1'b0;
            ld1      <= 1'b1;
            state    <= LOAD_A;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD_A: begin
          ld2   <= 1'b1;
          state <= LOAD_B;
        end
        LOAD_B: begin
          STRT  <= 1'b1;
          cnt   <= '0;
          state <= START;
        end
        START: begin
          shft_con <= 1'b1;
          cnt      <= '0;
          state    <= RUN;
        end
        // Counter value k means k+1 shift cycles have already been issued.
        RUN: begin
          if (cnt == CNT_LAST) begin
            state <= CAPTURE;
          end else begin
            cnt      <= cnt + CW'(1);
            shft_con <= 1'b1;
          end
        end
        CAPTURE: begin
          res       <= P;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl paired with a behavioural radix-2 shift-add core.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int W   = 4;
  localparam int LAT = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           in_valid = 1'b0;
  logic           res_ready = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_ready, ld1, ld2, STRT, shft_con, res_valid, busy;
  logic [W-1:0]   multicand, multiplier;
  logic [2*W-1:0] P, res;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  mult_seq_ctrl #(.WIDTH(W), .MULT_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .multicand(multicand), .multiplier(multiplier),
    .ld1(ld1), .ld2(ld2), .STRT(STRT), .shft_con(shft_con),
    .P(P), .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural shift-add multiplier core
  logic [W-1:0]   m_a = '0, m_b = '0, mb_sh = '0;
  logic [2*W-1:0] acc = '0;
  int             sh = 0;
  always @(posedge CLK) begin
    if (ld1) m_a <= multicand;
    if (ld2) m_b <= multiplier;
    if (STRT) begin
      acc   <= '0;
      sh    <= 0;
      mb_sh <= m_b;
    end else if (shft_con) begin
      if (mb_sh[0]) acc <= acc + ({{W{1'b0}}, m_a} << sh);
      mb_sh <= mb_sh >> 1;
      sh    <= sh + 1;
    end
  end
  assign P = acc;

  // Protocol monitor: strobe counters and violation tally
  int mon_cyc = 0, ld1_cnt = 0, ld2_cnt = 0, strt_cnt = 0, shft_cnt = 0;
  int ld1_t = 0, ld2_t = 0, strt_t = 0, shft_t = 0;
  int proto_viol = 0;
  logic prev_shft = 1'b0;
  logic [W-1:0] lat_a = '0, lat_b = '0;
  always @(negedge CLK) begin
    mon_cyc++;
    if (RST) begin
      if ((ld1 && ld2) || (ld1 && STRT) || (ld2 && STRT)) begin
        proto_viol++;
        $display("protocol violation: load/start strobes overlap at cycle %0d", mon_cyc);
      end
      if (shft_con && (!busy || res_valid || ld1 || ld2 || STRT)) begin
        proto_viol++;
        $display("protocol violation: shft_con outside RUN at cycle %0d", mon_cyc);
      end
      if (ld1) begin
        ld1_cnt++; ld1_t = mon_cyc; lat_a = multicand; lat_b = multiplier;
      end
      if ((ld2 || STRT || shft_con) && (multicand !== lat_a || multiplier !== lat_b)) begin
        proto_viol++;
        $display("protocol violation: operands moved at cycle %0d", mon_cyc);
      end
      if (ld2) begin ld2_cnt++; ld2_t = mon_cyc; end
      if (STRT) begin strt_cnt++; strt_t = mon_cyc; end
      if (shft_con) begin
        shft_cnt++;
        if (!prev_shft) shft_t = mon_cyc;
      end
      prev_shft = shft_con;
    end else begin
      prev_shft = 1'b0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives one operand pair and waits for res_valid; no checking here.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] e, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
    ok = res_valid;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    repeat (3) step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    checks++; if ({ld1, ld2, STRT, shft_con} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {ld1, ld2, STRT, shft_con}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL reset_res got=%h want=00", res); end
    checks++; if ({multicand, multiplier} !== 8'h00) begin failures++; $display("FAIL reset_operands got=%h want=00", {multicand, multiplier}); end
    RST = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    int lat, b1, b2, bs, bsh, pv0;
    bit ok;
    logic [2*W-1:0] e;
    b1 = ld1_cnt; b2 = ld2_cnt; bs = strt_cnt; bsh = shft_cnt; pv0 = proto_viol;
    res_ready = 1'b1;
    do_txn(4'b1011, 4'b1101, 8'h8F, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got res_valid=%b want=1", res_valid); end
    checks++; if (lat != 3 + LAT + 1) begin failures++; $display("FAIL single_latency got=%0d want=%0d", lat, 3 + LAT + 1); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (res !== e) begin failures++; $display("FAIL single_res got=%h want=%h", res, e); end
    checks++; if (ld1_cnt - b1 != 1 || ld2_cnt - b2 != 1 || strt_cnt - bs != 1) begin
      failures++; $display("FAIL single_pulse_count got ld1=%0d ld2=%0d strt=%0d want 1 each", ld1_cnt - b1, ld2_cnt - b2, strt_cnt - bs); end
    checks++; if (shft_cnt - bsh != LAT) begin failures++; $display("FAIL single_shift_cycles got=%0d want=%0d", shft_cnt - bsh, LAT); end
    checks++; if (ld2_t != ld1_t + 1 || strt_t != ld2_t + 1 || shft_t != strt_t + 1) begin
      failures++; $display("FAIL single_order got ld1=%0d ld2=%0d strt=%0d shft=%0d want consecutive", ld1_t, ld2_t, strt_t, shft_t); end
    step();
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL single_drain got res_valid=%b in_ready=%b want 0/1", res_valid, in_ready); end
    checks++; if (proto_viol != pv0) begin failures++; $display("FAIL single_protocol got=%0d want=%0d", proto_viol, pv0); end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[3] = '{4'hF, 4'h0, 4'h1};
    logic [W-1:0]   tb[3] = '{4'hF, 4'h9, 4'h7};
    logic [2*W-1:0] te[3] = '{8'hE1, 8'h00, 8'h07};
    int lat;
    bit ok;
    logic [2*W-1:0] e;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_txn(ta[i], tb[i], te[i], lat, ok);
      checks++; if (!ok) begin failures++; $display("FAIL corner%0d_timeout got res_valid=%b want=1", i, res_valid); end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (res !== e) begin failures++; $display("FAIL corner%0d_res got=%h want=%h", i, res, e); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat, bad, pv0;
    bit ok;
    logic [2*W-1:0] e;
    pv0 = proto_viol;
    res_ready = 1'b0;
    do_txn(4'b1011, 4'b1101, 8'h8F, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got res_valid=%b want=1", res_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    in_a = 4'h2;
    in_b = 4'h2;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (res_valid !== 1'b1 || res !== e || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b res=%h in_ready=%b want 1/%h/0", i, res_valid, res, in_ready, e);
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    step();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", res_valid); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release_idle got in_ready=%b busy=%b want 1/0", in_ready, busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept got busy=%b want=0", busy); end
    checks++; if (proto_viol != pv0) begin failures++; $display("FAIL bp_protocol got=%0d want=%0d", proto_viol, pv0); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   pa[2] = '{4'd3, 4'd6};
    logic [W-1:0]   pb[2] = '{4'd5, 4'd7};
    logic [2*W-1:0] pe[2] = '{8'd15, 8'd42};
    int hs_t[2] = '{0, 0};
    int idx = 0, nres = 0;
    bit hs;
    logic [2*W-1:0] e;
    res_ready = 1'b1;
    in_a = pa[0];
    in_b = pb[0];
    in_valid = 1'b1;
    for (int c = 0; c < 60 && nres < 2; c++) begin
      hs = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(pe[idx]);
        hs_t[idx] = c;
        idx++;
        hs = 1'b1;
      end
      if (res_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (res !== e) begin failures++; $display("FAIL b2b_res%0d got=%h want=%h", nres, res, e); end
        nres++;
      end
      step();
      if (hs) begin
        if (idx < 2) begin
          in_a = pa[idx];
          in_b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (nres != 2 || idx != 2) begin failures++; $display("FAIL b2b_count got results=%0d accepts=%0d want 2/2", nres, idx); end
    checks++; if (hs_t[1] - hs_t[0] != LAT + 6) begin failures++; $display("FAIL b2b_spacing got=%0d want=%0d", hs_t[1] - hs_t[0], LAT + 6); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit ok;
    logic [2*W-1:0] e;
    res_ready = 1'b1;
    in_a = 4'd5;
    in_b = 4'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !shft_con; i++) step();
    checks++; if (shft_con !== 1'b1) begin failures++; $display("FAIL midrst_reach_run got shft_con=%b want=1", shft_con); end
    step();
    RST = 1'b0;
    step();
    checks++; if ({ld1, ld2, STRT, shft_con} !== 4'b0) begin failures++; $display("FAIL midrst_ctrl got=%b want=0000", {ld1, ld2, STRT, shft_con}); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got res_valid=%b busy=%b want 0/0", res_valid, busy); end
    RST = 1'b1;
    step();
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release got res_valid=%b in_ready=%b want 0/1", res_valid, in_ready); end
    exp_q.delete();
    do_txn(4'd2, 4'd9, 8'd18, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout got res_valid=%b want=1", res_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (res !== e) begin failures++; $display("FAIL midrst_res got=%h want=%h", res, e); end
    checks++; if (lat != 3 + LAT + 1) begin failures++; $display("FAIL midrst_latency got=%0d want=%0d", lat, 3 + LAT + 1); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    checks++; if (proto_viol != 0) begin failures++; $display("FAIL protocol_total got=%0d want=0", proto_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
